// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-schedule constants and types
package aes_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_KEY_W  = 128;
  localparam int AES_WORD_W = 32;

  typedef logic [3:0] aes_round_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } aes_state_e;

  // Entry 0 is unused so that round r uses AES_RCON[r].
  localparam logic [7:0] AES_RCON [0:AES_NR] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, one byte in, one byte out
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - iterative AES-128 key schedule, one round key per rk_valid/rk_ready transfer
// Define AES_KEY_CACHE_EN to retain all eleven round keys for random-access readout via rk_rd_idx.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_load,
  input  logic [AES_KEY_W-1:0] key_in,
  output logic                 busy,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [AES_KEY_W-1:0] rk_out,
  output logic [3:0]           rk_round,
  output logic                 done,
  input  logic [3:0]           rk_rd_idx,
  output logic [AES_KEY_W-1:0] rk_rd_data
);

  if (NR != AES_NR) begin : g_nr_check
    $error("aes_key_expander: only NR=10 (AES-128) is supported");
  end

  localparam aes_round_t LAST_ROUND = aes_round_t'(NR);

  aes_state_e             state_q, state_d;
  logic [AES_KEY_W-1:0]   key_q, key_d;
  aes_round_t             round_q, round_d;
  logic                   done_q, done_d;
  logic                   key_we;

  logic [AES_WORD_W-1:0]  w0, w1, w2, w3;
  logic [AES_WORD_W-1:0]  rot_w3, sub_w3, temp;
  logic [AES_WORD_W-1:0]  n0, n1, n2, n3;
  logic [AES_KEY_W-1:0]   next_key;
  logic [7:0]             rcon;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .data_i (rot_w3[8*i +: 8]),
      .data_o (sub_w3[8*i +: 8])
    );
  end

  // Guard keeps the RCON index inside 1..10; next_key is unused at the last round.
  assign rcon     = (round_q < LAST_ROUND) ? AES_RCON[round_q + aes_round_t'(1)] : 8'h00;
  assign temp     = sub_w3 ^ {rcon, 24'h000000};
  assign n0       = w0 ^ temp;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    key_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_load) begin
          key_d   = key_in;
          round_d = '0;
          state_d = EXPAND;
          key_we  = 1'b1;
        end
      end
      EXPAND: begin
        if (rk_ready) begin
          if (round_q == LAST_ROUND) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = next_key;
            round_d = round_q + aes_round_t'(1);
            key_we  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == EXPAND);
  assign rk_valid = (state_q == EXPAND);
  assign rk_out   = key_q;
  assign rk_round = round_q;
  assign done     = done_q;

`ifdef AES_KEY_CACHE_EN
  logic [AES_KEY_W-1:0] cache_q [0:AES_NR];

  // Written alongside the key register so each slot holds the key shown for that round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= AES_NR; i++) begin
        cache_q[i] <= '0;
      end
    end else if (key_we) begin
      cache_q[round_d] <= key_d;
    end
  end

  assign rk_rd_data = (rk_rd_idx <= aes_round_t'(AES_NR)) ? cache_q[rk_rd_idx] : '0;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^{rk_rd_idx, key_we};
  assign rk_rd_data    = '0;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - self-checking bench for aes_key_expander against a FIPS-197 key-schedule model
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         done;
  logic [3:0]   rk_rd_idx = '0;
  logic [127:0] rk_rd_data;

  aes_key_expander dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load   (key_load),
    .key_in     (key_in),
    .busy       (busy),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_out     (rk_out),
    .rk_round   (rk_round),
    .done       (done),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int last_cyc = 0;
  logic [7:0]   sbox_tab [256];
  logic [127:0] obs [11];

  typedef struct {
    logic [127:0] key;
    int           round;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [7];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: S-box from GF(2^8) inversion plus affine map, schedule in FIPS word form.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] b = 8'h00;
    logic [7:0] s;
    if (a != 8'h00) begin
      for (int x = 1; x < 256; x++) begin
        if (gmul(a, 8'(x)) == 8'h01) b = 8'(x);
      end
    end
    s = b;
    for (int r = 1; r <= 4; r++) s = s ^ ((b << r) | (b >> (8 - r)));
    return s ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_ref(input int j);
    logic [7:0] r = 8'h01;
    for (int k = 1; k < j; k++) r = xtime(r);
    return r;
  endfunction

  task automatic expand_ref(input logic [127:0] key, output logic [127:0] ks [11]);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rcon_ref(i / 4), 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic start(input logic [127:0] k);
    @(negedge clk);
    key_in   = k;
    key_load = 1'b1;
  endtask

  // Follows one expansion from round 0; key_load is driven high with inj_key while the round index is in [inj_lo, inj_hi].
  task automatic expect_stream(input logic [127:0] key, input bit rnd, input int inj_lo,
                               input int inj_hi, input logic [127:0] inj_key);
    logic [127:0] ks [11];
    int idx = 0;
    int cyc = 0;
    expand_ref(key, ks);
    while (idx < 11 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      check("rk_valid", 128'(rk_valid), 128'(1));
      check("busy", 128'(busy), 128'(1));
      check("done_low", 128'(done), 128'(0));
      check($sformatf("rk_round_r%0d", idx), 128'(rk_round), 128'(idx));
      check($sformatf("rk_out_r%0d", idx), rk_out, ks[idx]);
      key_load = (idx >= inj_lo && idx <= inj_hi);
      if (key_load) key_in = inj_key;
      rk_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (rk_ready) begin
        obs[idx] = rk_out;
        idx++;
      end
    end
    last_cyc = cyc;
    if (idx < 11) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout rounds=%0d required=11", idx);
    end
    @(negedge clk);
    check("done_pulse", 128'(done), 128'(1));
    check("busy_after", 128'(busy), 128'(0));
    check("valid_after", 128'(rk_valid), 128'(0));
    check("round_hold", 128'(rk_round), 128'(10));
    check("out_hold", rk_out, ks[10]);
    rk_ready = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_valid"}, 128'(rk_valid), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_out"}, rk_out, 128'(0));
    check({tag, "_round"}, 128'(rk_round), 128'(0));
  endtask

  initial begin
    logic [127:0] ks [11];
    logic [127:0] prev_key;
    logic [127:0] ka, kb;

    for (int a = 0; a < 256; a++) sbox_tab[a] = sbox_ref(8'(a));

    vecs[0] = '{key: FIPS_KEY, round: 0,  exp: FIPS_KEY};
    vecs[1] = '{key: FIPS_KEY, round: 1,  exp: 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{key: FIPS_KEY, round: 2,  exp: 128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{key: FIPS_KEY, round: 3,  exp: 128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[4] = '{key: FIPS_KEY, round: 10, exp: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[5] = '{key: 128'h0,   round: 1,  exp: 128'h62636363626363636263636362636363};
    vecs[6] = '{key: 128'h0,   round: 2,  exp: 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};

    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;

    // Known-answer vectors, continuous ready: first key one cycle after key_load, 11 back-to-back keys.
    prev_key = 128'hx;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].key !== prev_key) begin
        start(vecs[i].key);
        expect_stream(vecs[i].key, 1'b0, -1, -1, '0);
        check("valid_cycles", 128'(last_cyc), 128'(11));
        @(negedge clk);
        check("done_one_cycle", 128'(done), 128'(0));
        prev_key = vecs[i].key;
      end
      check($sformatf("table%0d", i), obs[vecs[i].round], vecs[i].exp);
    end

    // Same key with pseudo-random back-pressure.
    start(FIPS_KEY);
    expect_stream(FIPS_KEY, 1'b1, -1, -1, '0);
    expand_ref(FIPS_KEY, ks);
`ifdef AES_KEY_CACHE_EN
    for (int i = 0; i < 11; i++) begin
      rk_rd_idx = 4'(i);
      #1;
      check($sformatf("cache_r%0d", i), rk_rd_data, ks[i]);
    end
    rk_rd_idx = 4'd12;
    #1;
    check("cache_idx12", rk_rd_data, 128'(0));
    rk_rd_idx = 4'd15;
    #1;
    check("cache_idx15", rk_rd_data, 128'(0));
`else
    rk_rd_idx = 4'd10;
    #1;
    check("nocache_idx10", rk_rd_data, 128'(0));
    rk_rd_idx = 4'd0;
    #1;
    check("nocache_idx0", rk_rd_data, 128'(0));
`endif

    // key_load with a different key at round 4 is ignored.
    kb = {$urandom, $urandom, $urandom, $urandom};
    start(FIPS_KEY);
    expect_stream(FIPS_KEY, 1'b0, 4, 4, kb);
    start(FIPS_KEY);
    expect_stream(FIPS_KEY, 1'b1, 4, 4, kb);

    // Asynchronous reset at round 6 clears everything without a done pulse.
    ka = {$urandom, $urandom, $urandom, $urandom};
    start(ka);
    rk_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      key_load = 1'b0;
      if (rk_round == 4'd6) break;
    end
    check("reached_r6", 128'(rk_round), 128'(6));
    #2 rst_n = 1'b0;
    #1 check_idle_zero("async_rst");
    @(negedge clk);
    check_idle_zero("rst_hold");
    rst_n = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    check_idle_zero("post_rst");
`ifdef AES_KEY_CACHE_EN
    rk_rd_idx = 4'd3;
    #1;
    check("cache_cleared", rk_rd_data, 128'(0));
`endif
    kb = {$urandom, $urandom, $urandom, $urandom};
    start(kb);
    expect_stream(kb, 1'b1, -1, -1, '0);

    // key_load held high across done: next expansion starts right after the done cycle.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    start(ka);
    expect_stream(ka, 1'b0, 0, 10, kb);
    expect_stream(kb, 1'b0, -1, -1, '0);

    // Random keys under random back-pressure.
    for (int n = 0; n < 4; n++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      start(ka);
      expect_stream(ka, 1'b1, -1, -1, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
